// File: rtl/ps2_keyboard_mmio.sv
// ps2_keyboard_mmio
// Receives PS/2 keyboard frames and buffers the scan codes in a FIFO. The core
// reads them through an 8-byte memory-mapped window. Every read returns a
// registered word and a one-cycle acknowledge.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-low reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_dat   raw PS/2 data pin (asynchronous)
//   rd_req    one-cycle read strobe from the core
//   rd_addr   byte address, sampled with rd_req
//   rd_data   read result. It is valid with rd_ack and held until the next ack.
//   rd_ack    one-cycle pulse, one cycle after an in-window rd_req
//   addr_err  one-cycle pulse, one cycle after a misaligned in-window rd_req
//   irq       level signal, high while the FIFO is non-empty
//
// Register window (base KBD_BASE)
//   +0 DATA   {23'd0, nonempty, head}. A read pops the head entry.
//   +4 STATUS {16'd0, count, 5'd0, perr, ovf, nonempty}. A read clears the sticky bits.
//
// Build option
//   PS2_PARITY_CHECK_EN  Checks odd parity. A frame with bad parity is dropped
//                        and sets perr.

module ps2_keyboard_mmio #(
   parameter logic [31:0] KBD_BASE    = 32'h0008_0000,
   parameter int          FIFO_DEPTH  = 16,     // power of two, 2..128
   parameter int          FILTER_LEN  = 8,      // 2 or more
   parameter int          TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_ack,
   output logic        addr_err,
   output logic        irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

   // ---------------- input conditioning ----------------
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          filt_clk, strobe;
   logic [FW-1:0] fcnt;

   // NOTE: all state uses non-blocking assignments. Every register then
   // samples the pre-edge value, so this shift chain is a real 2-FF synchroniser.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_dat;
         dat_s2 <= dat_s1;
      end
   end

   // The filtered clock flips only after FILTER_LEN consecutive samples that
   // disagree with it. A falling flip produces a one-cycle sample strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_clk <= 1'b1;
         fcnt     <= '0;
         strobe   <= 1'b0;
      end else begin
         strobe <= 1'b0;
         if (clk_s2 != filt_clk) begin
            if (fcnt == FW'(FILTER_LEN - 1)) begin
               filt_clk <= clk_s2;
               fcnt     <= '0;
               strobe   <= filt_clk;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   // ---------------- frame receiver ----------------
   rx_state_t     state;
   logic [7:0]    shreg;
   logic [2:0]    bitcnt;
   logic          par;          // XOR of data bits and parity bit
   logic [TW-1:0] tcnt;
   logic          push_req, perr_set;
   logic [7:0]    push_byte;
   logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = par;
`else
   logic unused_par;
   assign unused_par = par;
   assign par_ok     = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         par       <= 1'b0;
         tcnt      <= '0;
         push_req  <= 1'b0;
         push_byte <= '0;
         perr_set  <= 1'b0;
      end else begin
         push_req <= 1'b0;
         perr_set <= 1'b0;
         if (strobe) begin
            tcnt <= '0;
            case (state)
               S_IDLE: if (!dat_s2) begin
                  state  <= S_DATA;
                  bitcnt <= '0;
                  par    <= 1'b0;
               end
               S_DATA: begin
                  shreg  <= {dat_s2, shreg[7:1]};
                  par    <= par ^ dat_s2;
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
                  par   <= par ^ dat_s2;
                  state <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if (dat_s2 && par_ok) begin
                     push_req  <= 1'b1;
                     push_byte <= shreg;
                  end else begin
                     perr_set <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else if (state != S_IDLE) begin
            // A stalled keyboard must not leave the receiver mid-frame forever.
            if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
               state <= S_IDLE;
               tcnt  <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

   // ---------------- FIFO and register window ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          perr_sticky, ovf_sticky;
   logic          nonempty, full, in_win, misal, data_rd, stat_rd, pop, push_ok;

   assign nonempty = (count != '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign in_win   = rd_req && (rd_addr[31:3] == KBD_BASE[31:3]);
   assign misal    = (rd_addr[1:0] != 2'b00);
   assign data_rd  = in_win && !misal && !rd_addr[2];
   assign stat_rd  = in_win && !misal &&  rd_addr[2];
   assign pop      = data_rd && nonempty;
   // A pop in the same cycle frees the slot that a full FIFO needs.
   assign push_ok  = push_req && (!full || pop);
   assign irq      = nonempty;

   // NOTE: the storage array has no reset. The pointers and the count define
   // which entries are valid, so resetting the data would only cost flops.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= push_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         perr_sticky <= 1'b0;
         ovf_sticky  <= 1'b0;
         rd_data     <= '0;
         rd_ack      <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // A flag raised in the same cycle as the clear wins.
         perr_sticky <= perr_set | (perr_sticky & ~stat_rd);
         ovf_sticky  <= (push_req & ~push_ok) | (ovf_sticky & ~stat_rd);

         rd_ack   <= in_win;
         addr_err <= in_win && misal;
         if (in_win) begin
            if (misal)
               rd_data <= '0;
            else if (rd_addr[2])
               rd_data <= {16'd0, 8'(count), 5'd0, perr_sticky, ovf_sticky, nonempty};
            else if (nonempty)
               rd_data <= {23'd0, 1'b1, mem[rptr]};
            else
               rd_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
module tb_ps2_keyboard_mmio;

   localparam logic [31:0] B       = 32'h0008_0000;
   localparam int          DEPTH   = 16;
   localparam int          TIMEOUT = 1000;
   localparam int          HALF    = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic        rd_req = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_ack, addr_err, irq;

   int n_checks = 0;
   int n_fail   = 0;

   ps2_keyboard_mmio #(
      .KBD_BASE(B), .FIFO_DEPTH(DEPTH), .FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_ack(rd_ack), .addr_err(addr_err), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Sends the first nbits of an 11-bit frame: start, 8 data bits LSB first,
   // odd parity, stop. The device changes data while the clock is high.
   task automatic send_frame(input logic [7:0] code, input bit bad_par,
                             input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_dat = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic ack, output logic err, output logic irq_s,
                          output logic ack_next);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = addr;
      @(negedge clk);
      rd_req = 1'b0;
      data   = rd_data;
      ack    = rd_ack;
      err    = addr_err;
      irq_s  = irq;
      @(negedge clk);
      ack_next = rd_ack;
   endtask

   task automatic read_expect(input string name, input logic [31:0] addr,
                              input logic [31:0] exp);
      logic [31:0] d;
      logic a, e, q, an;
      do_read(addr, d, a, e, q, an);
      check({name, " ack"}, 32'(a), 32'd1);
      check({name, " data"}, d, exp);
   endtask

   typedef struct {
      bit          send;
      logic [7:0]  code;
      bit          bad_stop;
      logic [31:0] addr;
      logic        exp_ack;
      logic        exp_err;
      logic [31:0] exp_data;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [31:0] d;
      logic a, e, q, an;

      vecs[0]  = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0000, 0};
      vecs[1]  = '{0, 8'h00, 0, B,     1, 0, 32'h0000_0000, 0};
      vecs[2]  = '{1, 8'h1C, 0, B,     0, 0, 32'h0,         1};
      vecs[3]  = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0101, 1};
      vecs[4]  = '{0, 8'h00, 0, B,     1, 0, 32'h0000_011C, 0};
      vecs[5]  = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0000, 0};
      vecs[6]  = '{1, 8'h5A, 0, B,     0, 0, 32'h0,         1};
      vecs[7]  = '{1, 8'h03, 0, B,     0, 0, 32'h0,         1};
      vecs[8]  = '{0, 8'h00, 0, B + 2, 1, 1, 32'h0000_0000, 1};
      vecs[9]  = '{0, 8'h00, 0, B + 8, 0, 0, 32'h0000_0000, 1};
      vecs[10] = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0201, 1};
      vecs[11] = '{0, 8'h00, 0, B,     1, 0, 32'h0000_015A, 1};
      vecs[12] = '{0, 8'h00, 0, B,     1, 0, 32'h0000_0103, 0};
      vecs[13] = '{1, 8'h77, 1, B,     0, 0, 32'h0,         0};
      vecs[14] = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0004, 0};
      vecs[15] = '{0, 8'h00, 0, B + 4, 1, 0, 32'h0000_0000, 0};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset rd_data", rd_data, 32'h0);
      check("reset rd_ack", 32'(rd_ack), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].send) begin
            send_frame(vecs[i].code, 1'b0, vecs[i].bad_stop, 11);
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
         end else begin
            do_read(vecs[i].addr, d, a, e, q, an);
            check($sformatf("vec%0d ack", i), 32'(a), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d addr_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d irq", i), 32'(q), 32'(vecs[i].exp_irq));
            check($sformatf("vec%0d ack pulse", i), 32'(an), 32'd0);
         end
      end

      // Overflow: DEPTH+1 frames. The last one is dropped.
      for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0, 11);
      read_expect("ovf status1", B + 4, 32'h0000_1003);
      read_expect("ovf status2", B + 4, 32'h0000_1001);
      for (int i = 1; i <= DEPTH; i++)
         read_expect($sformatf("ovf data%0d", i), B, 32'h100 | 32'(i));
      check("ovf drained irq", 32'(irq), 32'd0);

      // Parity error
      send_frame(8'h1C, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
      read_expect("bad parity status", B + 4, 32'h0000_0004);
      check("bad parity irq", 32'(irq), 32'd0);
`else
      read_expect("bad parity status", B + 4, 32'h0000_0101);
      read_expect("bad parity data", B, 32'h0000_011C);
`endif
      read_expect("post parity status", B + 4, 32'h0000_0000);

      // Mid-frame timeout, then a clean frame
      send_frame(8'h99, 1'b0, 1'b0, 4);
      repeat (TIMEOUT + 50) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, 11);
      read_expect("timeout status", B + 4, 32'h0000_0101);
      read_expect("timeout data", B, 32'h0000_015A);

      // A short clock glitch with data low must not start a frame
      @(negedge clk);
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      ps2_dat = 1'b1;
      send_frame(8'hA1, 1'b0, 1'b0, 11);
      send_frame(8'hB2, 1'b0, 1'b0, 11);

      // Back-to-back DATA reads on consecutive cycles
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = B;
      @(negedge clk);
      check("b2b read1", rd_data, 32'h0000_01A1);
      @(negedge clk);
      check("b2b read2", rd_data, 32'h0000_01B2);
      @(negedge clk);
      rd_req = 1'b0;
      check("b2b read3 data", rd_data, 32'h0);
      check("b2b read3 ack", 32'(rd_ack), 32'd1);
      read_expect("b2b status", B + 4, 32'h0000_0000);

      // Reset mid-frame and mid-read
      send_frame(8'h22, 1'b0, 1'b0, 11);
      check("pre-reset irq", 32'(irq), 32'd1);
      send_frame(8'h33, 1'b0, 1'b0, 5);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = B;
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset pending ack", 32'(rd_ack), 32'd0);
      check("reset irq clear", 32'(irq), 32'd0);
      check("reset rd_data clear", rd_data, 32'h0);
      rd_req = 1'b0;
      rst    = 1'b1;
      repeat (2) @(negedge clk);
      read_expect("post reset status", B + 4, 32'h0000_0000);
      send_frame(8'h44, 1'b0, 1'b0, 11);
      read_expect("post reset data", B, 32'h0000_0144);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
